// File: rtl/branch_target_table_if.sv
// branch_target_table_if: lookup, write, clear and response signals of the branch target table
interface branch_target_table_if #(
  parameter int PC_W         = 8,
  parameter int NUM_PROBS    = 4,
  parameter int LOOP_ENTRIES = 8,
  parameter int COND_ENTRIES = 16
);
  localparam int PW = $clog2(NUM_PROBS);
  localparam int LW = $clog2(LOOP_ENTRIES);
  localparam int CW = $clog2(COND_ENTRIES);
  logic [PW-1:0]   problem;
  logic            loop_branch;
  logic [LW-1:0]   Jptr_b;
  logic [CW-1:0]   Jptr_con;
  logic            req_valid;
  logic            req_ready;
  logic            wr_en;
  logic [PW-1:0]   wr_prob;
  logic            wr_bank;
  logic [CW-1:0]   wr_idx;
  logic [PC_W-1:0] wr_data;
  logic            clear_req;
  logic            rsp_valid;
  logic [PC_W-1:0] Jump;
  logic            miss;
  logic            busy;
  modport master (
    output problem, loop_branch, Jptr_b, Jptr_con, req_valid,
           wr_en, wr_prob, wr_bank, wr_idx, wr_data, clear_req,
    input  req_ready, rsp_valid, Jump, miss, busy
  );
  modport slave (
    input  problem, loop_branch, Jptr_b, Jptr_con, req_valid,
           wr_en, wr_prob, wr_bank, wr_idx, wr_data, clear_req,
    output req_ready, rsp_valid, Jump, miss, busy
  );
endinterface

// File: rtl/branch_target_table.sv
// branch_target_table: two-bank per-problem jump target table with registered lookup and sweep clear
module branch_target_table #(
  parameter int PC_W         = 8,
  parameter int NUM_PROBS    = 4,
  parameter int LOOP_ENTRIES = 8,
  parameter int COND_ENTRIES = 16
) (
  input logic                 Clk,
  input logic                 Reset_n,
  branch_target_table_if.slave bus
);
  localparam int PW = $clog2(NUM_PROBS);
  localparam int LW = $clog2(LOOP_ENTRIES);
  localparam int CW = $clog2(COND_ENTRIES);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     cnt, cnt_nx;
  logic [PC_W-1:0]   loop_mem [NUM_PROBS][LOOP_ENTRIES];
  logic [PC_W-1:0]   cond_mem [NUM_PROBS][COND_ENTRIES];
  logic [LOOP_ENTRIES-1:0] loop_vld [NUM_PROBS];
  logic [COND_ENTRIES-1:0] cond_vld [NUM_PROBS];
  logic              ready, lk, rd_ok, rd_vld, hit, wr_ok, byp;
  logic [LW-1:0]     wr_lidx;
  logic [PC_W-1:0]   rd_data;
  logic              rsp_valid, miss;
  logic [PC_W-1:0]   jump;

  assign ready   = state == IDLE;
  assign lk      = bus.req_valid && ready;
  assign wr_lidx = bus.wr_idx[LW-1:0];
  assign rd_ok   = 32'(bus.problem) < NUM_PROBS &&
                   (bus.loop_branch ? 32'(bus.Jptr_b) < LOOP_ENTRIES : 32'(bus.Jptr_con) < COND_ENTRIES);
  assign rd_vld  = bus.loop_branch ? loop_vld[bus.problem][bus.Jptr_b] : cond_vld[bus.problem][bus.Jptr_con];
  assign rd_data = bus.loop_branch ? loop_mem[bus.problem][bus.Jptr_b] : cond_mem[bus.problem][bus.Jptr_con];
  assign hit     = rd_ok && rd_vld;
  assign wr_ok   = bus.wr_en && ready && 32'(bus.wr_prob) < NUM_PROBS &&
                   (bus.wr_bank ? 32'(wr_lidx) < LOOP_ENTRIES : 32'(bus.wr_idx) < COND_ENTRIES);
  // a write landing on the looked-up entry in the same cycle is forwarded to the response
  assign byp     = wr_ok && bus.wr_prob == bus.problem && bus.wr_bank == bus.loop_branch &&
                   (bus.loop_branch ? wr_lidx == bus.Jptr_b : bus.wr_idx == bus.Jptr_con);

  assign bus.req_ready = ready;
  assign bus.busy      = state == CLEAR;
  assign bus.rsp_valid = rsp_valid;
  assign bus.Jump      = jump;
  assign bus.miss      = miss;

  // sweep state register and problem counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // sweep walks one problem per cycle and returns to idle after the last one
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == IDLE && bus.clear_req) begin
      state_nx = CLEAR;
      cnt_nx   = '0;
    end else if (state == CLEAR) begin
      cnt_nx   = cnt + 1'b1;
      state_nx = 32'(cnt) == NUM_PROBS - 1 ? IDLE : CLEAR;
    end
  end

  // target storage has no reset; only valid bits qualify its contents
  always_ff @(posedge Clk) begin
    if (wr_ok && bus.wr_bank) loop_mem[bus.wr_prob][wr_lidx] <= bus.wr_data;
    if (wr_ok && !bus.wr_bank) cond_mem[bus.wr_prob][bus.wr_idx] <= bus.wr_data;
  end

  // valid bits: set by accepted writes, cleared per problem by the sweep
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PROBS; p++) begin
        loop_vld[p] <= '0;
        cond_vld[p] <= '0;
      end
    end else begin
      if (wr_ok && bus.wr_bank) loop_vld[bus.wr_prob][wr_lidx] <= 1'b1;
      if (wr_ok && !bus.wr_bank) cond_vld[bus.wr_prob][bus.wr_idx] <= 1'b1;
      if (state == CLEAR) begin
        loop_vld[cnt] <= '0;
        cond_vld[cnt] <= '0;
      end
    end
  end

  // registered lookup response; target and miss hold when no request is accepted
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rsp_valid <= 1'b0;
      jump      <= '0;
      miss      <= 1'b0;
    end else begin
      rsp_valid <= lk;
      if (lk) begin
        jump <= byp ? bus.wr_data : hit ? rd_data : '0;
        miss <= !(byp || hit);
      end
    end
  end
endmodule

// File: tb/tb_branch_target_table.sv
// tb_branch_target_table: scoreboard bench with a table-level reference model
module tb_branch_target_table;
  localparam int NP = 4;

  typedef struct {
    int         due;
    logic [7:0] j;
    logic       m;
  } exp_t;

  logic Clk, Reset_n;
  int   cyc, total, bad, busy_left;
  exp_t exp_q[$];
  exp_t e;
  logic [7:0] lm [NP][8];
  logic [7:0] cm [NP][16];
  bit         lv [NP][8];
  bit         cv [NP][16];
  logic [7:0] last_j;
  logic       last_m;

  branch_target_table_if bus ();

  branch_target_table dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  initial Clk = 0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  task automatic invalidate_all();
    for (int p = 0; p < NP; p++) begin
      for (int i = 0; i < 8; i++) lv[p][i] = 0;
      for (int i = 0; i < 16; i++) cv[p][i] = 0;
    end
  endtask

  // one clock of the model: writes commit before a same-cycle read sees them
  task automatic tick();
    logic       rdy, m;
    logic [7:0] j;
    rdy = busy_left == 0;
    chk("busy", bus.busy, !rdy);
    chk("req_ready", bus.req_ready, rdy);
    if (bus.wr_en && rdy) begin
      if (bus.wr_bank) begin
        lm[bus.wr_prob][bus.wr_idx[2:0]] = bus.wr_data;
        lv[bus.wr_prob][bus.wr_idx[2:0]] = 1;
      end else begin
        cm[bus.wr_prob][bus.wr_idx] = bus.wr_data;
        cv[bus.wr_prob][bus.wr_idx] = 1;
      end
    end
    if (bus.req_valid && rdy) begin
      m = bus.loop_branch ? !lv[bus.problem][bus.Jptr_b] : !cv[bus.problem][bus.Jptr_con];
      j = m ? 8'h0 : bus.loop_branch ? lm[bus.problem][bus.Jptr_b] : cm[bus.problem][bus.Jptr_con];
      exp_q.push_back('{cyc + 1, j, m});
    end
    if (bus.clear_req && rdy) begin
      invalidate_all();
      busy_left = NP;
    end else if (busy_left > 0) busy_left--;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drv(bit rv, int p, bit lb, int jb, int jc,
                     bit we, int wp, bit wb, int wi, int wd, bit clr);
    bus.req_valid   = rv;
    bus.problem     = 2'(p);
    bus.loop_branch = lb;
    bus.Jptr_b      = 3'(jb);
    bus.Jptr_con    = 4'(jc);
    bus.wr_en       = we;
    bus.wr_prob     = 2'(wp);
    bus.wr_bank     = wb;
    bus.wr_idx      = 4'(wi);
    bus.wr_data     = 8'(wd);
    bus.clear_req   = clr;
    tick();
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(int p, bit b, int i, int d);
    drv(0, 0, 0, 0, 0, 1, p, b, i, d, 0);
  endtask

  task automatic rd(int p, bit b, int i);
    drv(1, p, b, i, i, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_now();
    #2 Reset_n = 0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    invalidate_all();
    busy_left = 0;
    exp_q.delete();
    @(negedge Clk);
    Reset_n = 1;
  endtask

  // monitor: a due response must appear exactly then; otherwise outputs hold
  always @(negedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_j = 0;
      last_m = 0;
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("Jump", bus.Jump, e.j);
      chk("miss", bus.miss, e.m);
      last_j = e.j;
      last_m = e.m;
    end else begin
      chk("rsp_idle", bus.rsp_valid, 0);
      chk("Jump_hold", bus.Jump, last_j);
      chk("miss_hold", bus.miss, last_m);
    end
  end

  initial begin
    cyc = 0; total = 0; bad = 0; busy_left = 0;
    invalidate_all();
    Reset_n = 0;
    bus.req_valid = 0; bus.problem = 0; bus.loop_branch = 0; bus.Jptr_b = 0; bus.Jptr_con = 0;
    bus.wr_en = 0; bus.wr_prob = 0; bus.wr_bank = 0; bus.wr_idx = 0; bus.wr_data = 0; bus.clear_req = 0;
    @(negedge Clk);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_Jump", bus.Jump, 0);
    chk("reset_miss", bus.miss, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_ready", bus.req_ready, 1);
    Reset_n = 1;
    idle();
    rd(0, 0, 3);
    wr(1, 0, 3, 66);
    rd(1, 0, 3);
    rd(1, 1, 3);
    drv(1, 2, 1, 1, 0, 1, 2, 1, 1, 61, 0);
    idle();
    wr(0, 0, 5, 11); wr(1, 1, 6, 12); wr(2, 0, 15, 13); wr(3, 1, 7, 14);
    rd(2, 0, 15);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    wr(0, 0, 7, 99);
    rd(0, 0, 7);
    idle(); idle();
    idle();
    rd(0, 0, 5); rd(1, 1, 6); rd(2, 0, 15); rd(3, 1, 7); rd(0, 0, 7);
    idle();
    drv(0, 0, 0, 0, 0, 1, 0, 0, 9, 77, 1);
    idle(); idle(); idle(); idle();
    rd(0, 0, 9);
    wr(3, 1, 2, 44);
    rd(3, 1, 2);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    reset_now();
    rd(3, 1, 2);
    idle();
    wr(0, 0, 1, 30); wr(1, 1, 4, 25); wr(2, 0, 9, 33);
    rd(0, 0, 1); rd(1, 1, 4); rd(2, 0, 9);
    idle(); idle();
    for (int n = 0; n < 400; n++) begin
      bit wb;
      wb = 1'($urandom);
      drv(1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 15),
          1'($urandom), $urandom_range(0, 3), wb, wb ? $urandom_range(0, 7) : $urandom_range(0, 15),
          $urandom_range(0, 255), $urandom_range(0, 39) == 0);
    end
    idle(); idle(); idle(); idle(); idle();
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_target_table.md
Name: branch_target_table

Overview:
- Programmable, parametrised successor to the fixed branch-target lookup in the fetch stage.
- Holds per-problem jump targets in two banks:
  - loop bank, selected by loop_branch=1
  - conditional bank, selected by loop_branch=0
- Targets are loaded at run time through a write port instead of being hard-coded.
- Lookups are registered (1-cycle latency) and carry a miss flag; a sweep FSM invalidates the table on request.

Parameters:
- PC_W, 8, width of a jump target.
- NUM_PROBS, 4, number of problem contexts.
- LOOP_ENTRIES, 8, entries per problem in the loop bank.
- COND_ENTRIES, 16, entries per problem in the conditional bank.
- Derived widths (not overridable): PW=$clog2(NUM_PROBS); LW=$clog2(LOOP_ENTRIES); CW=$clog2(COND_ENTRIES).

Ports:
- Clk  in  1  clock; all state on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- problem  in  PW  lookup problem select.
- loop_branch  in  1  1 = loop bank, 0 = conditional bank.
- Jptr_b  in  LW  loop-bank index.
- Jptr_con  in  CW  conditional-bank index.
- req_valid  in  1  lookup request.
- req_ready  out  1  table can accept lookups/writes.
- wr_en  in  1  write entry.
- wr_prob  in  PW  write problem.
- wr_bank  in  1  1 = loop bank, 0 = conditional bank.
- wr_idx  in  CW  write index; loop bank uses the low LW bits.
- wr_data  in  PC_W  target to store.
- clear_req  in  1  start invalidate sweep.
- rsp_valid  out  1  lookup result valid.
- Jump  out  PC_W  target.
- miss  out  1  entry invalid.
- busy  out  1  sweep in progress.

Behaviour:
- Reset (async, Reset_n=0):
  - All valid bits cleared.
  - FSM to IDLE.
  - rsp_valid=0, Jump=0, miss=0, busy=0, req_ready=1.
  - Target storage is not reset.
- FSM states:
  - IDLE: clear_req=1 moves to CLEAR with sweep counter=0. busy=1 and req_ready=0 from the following cycle.
  - CLEAR: each cycle clears all valid bits of problem[counter] in both banks, then increments the counter. When counter==NUM_PROBS-1, the clear completes that cycle and the FSM returns to IDLE. The sweep therefore takes exactly NUM_PROBS cycles.
  - clear_req asserted while in CLEAR is ignored.
- Lookup:
  - Accepted when req_valid && req_ready.
  - Next cycle: rsp_valid=1, Jump = stored target, miss=0 if the entry's valid bit is set.
  - If the entry is invalid: miss=1, Jump=0.
  - With no accepted request, rsp_valid=0 next cycle; Jump and miss hold their previous values.
  - Bank/index select: Jptr_b when loop_branch=1, Jptr_con when loop_branch=0.
- Write:
  - Accepted when wr_en && req_ready.
  - Stores wr_data and sets the valid bit at the clock edge.
  - Writes while busy are dropped with no effect.
- Lookup and write to the same entry in the same cycle: the response returns the new wr_data with miss=0 (write-through bypass).
- clear_req and wr_en in the same IDLE cycle: the write commits, then the sweep invalidates it; the entry reads as a miss after the sweep.
- Reset asserted mid-sweep: immediate return to IDLE, all valid bits cleared.
- Out-of-range index (COND_ENTRIES or LOOP_ENTRIES not a power of two, index ≥ entries):
  - Lookup returns miss=1.
  - Write is dropped.
- Out-of-range problem index (≥ NUM_PROBS): treated the same way, lookup returns miss=1 and write is dropped.

Test Plan:
- Reset, then lookup problem=0, loop_branch=0, Jptr_con=3 -> next cycle rsp_valid=1, miss=1, Jump=0.
- Write prob=1, bank=0, idx=3, data=66; then lookup problem=1, loop_branch=0, Jptr_con=3 -> Jump=66, miss=0. The same lookup with loop_branch=1, Jptr_b=3 -> miss=1 (banks independent).
- Same-cycle write (prob=2, bank=1, idx=1, data=61) and lookup (problem=2, loop_branch=1, Jptr_b=1) -> response Jump=61, miss=0.
- Load 4 entries, pulse clear_req -> busy=1 for exactly 4 cycles, req_ready=0, a write during busy is dropped. Afterwards all 4 lookups -> miss=1.
- Assert Reset_n=0 on the 2nd sweep cycle -> busy=0 and rsp_valid=0 immediately. After release, a previously written entry reads miss=1.
- Back-to-back lookups on 3 consecutive cycles to entries holding 30, 25, 33 -> rsp_valid high 3 cycles, Jump=30, 25, 33 in order, each one cycle after its request.
